// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiters.
// rr_next returns the first requester after 'last', wrapping modulo n.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int MAX_MASTERS = 16;

  // Falls back to 'last' when nothing is requesting.
  function automatic int rr_next(input logic [MAX_MASTERS-1:0] req, input int last, input int n);
    int   idx;
    int   pick;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[3:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational one-hot round-robin picker: the first set req bit after
// 'last' (wrapping) wins. gnt is all zero when req is zero.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [MAX_MASTERS-1:0] req_ext;
  int                     sel;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    sel            = rr_next(req_ext, int'(last), N);
    gnt            = '0;
    idx            = '0;
    for (int i = 0; i < N; i++) begin
      if ((|req) && (sel == i)) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner holds the slave bus for its whole
// CYC; a per-transfer watchdog ends hung accesses with ERR and an abort phase.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_MASTERS     = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR    [N_MASTERS-1:0],
  input  logic [2:0]                 CTI    [N_MASTERS-1:0],
  input  logic [1:0]                 BTE    [N_MASTERS-1:0],
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W  [N_MASTERS-1:0],
  input  logic [WB_DATA_WIDTH/8-1:0] SEL    [N_MASTERS-1:0],
  input  logic                       CYC    [N_MASTERS-1:0],
  input  logic                       STB    [N_MASTERS-1:0],
  input  logic                       WE     [N_MASTERS-1:0],
  output logic [WB_DATA_WIDTH-1:0]   DAT_R  [N_MASTERS-1:0],
  output logic                       ACK    [N_MASTERS-1:0],
  output logic                       ERR    [N_MASTERS-1:0],
  output logic [WB_ADDR_WIDTH-1:0]   SADR,
  output logic [2:0]                 SCTI,
  output logic [1:0]                 SBTE,
  output logic [WB_DATA_WIDTH-1:0]   SDAT_W,
  output logic [WB_DATA_WIDTH/8-1:0] SSEL,
  output logic                       SCYC,
  output logic                       SSTB,
  output logic                       SWE,
  input  logic [WB_DATA_WIDTH-1:0]   SDAT_R,
  input  logic                       SACK,
  input  logic                       SERR,
  output logic [N_MASTERS-1:0]       GNT
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  arb_state_t             state_reg, state_next;
  logic [N_MASTERS-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]          owner_reg, owner_next;
  logic [IW-1:0]          last_reg, last_next;
  logic [CW-1:0]          cnt_reg, cnt_next;

  logic [N_MASTERS-1:0]   cyc_vec;
  logic [N_MASTERS-1:0]   pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic [N_MASTERS-1:0]   ack_vec, err_vec;

  logic                     own_cyc, own_stb, own_we;
  logic [WB_ADDR_WIDTH-1:0] own_adr;
  logic [WB_DATA_WIDTH-1:0] own_dat;
  logic [SW-1:0]            own_sel;
  logic [2:0]               own_cti;
  logic [1:0]               own_bte;
  logic                     req_active, waiting, timeout_hit;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_port
    assign cyc_vec[gi] = CYC[gi];
    assign ACK[gi]     = ack_vec[gi];
    assign ERR[gi]     = err_vec[gi];
    assign DAT_R[gi]   = SDAT_R;
  end

  wb_rr_pick #(.N(N_MASTERS)) u_pick (
    .req  (cyc_vec),
    .last (last_reg),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // Owner's request, selected by index for the slave-side mux.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    own_bte = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner_reg == IW'(i)) begin
        own_cyc = CYC[i];
        own_stb = STB[i];
        own_we  = WE[i];
        own_adr = ADR[i];
        own_dat = DAT_W[i];
        own_sel = SEL[i];
        own_cti = CTI[i];
        own_bte = BTE[i];
      end
    end
  end

  // A termination from the slave beats a same-cycle watchdog expiry.
  assign req_active  = (state_reg == OWN) && own_cyc && own_stb;
  assign waiting     = req_active && !SACK && !SERR;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = '0;
    SCYC       = 1'b0;
    SSTB       = 1'b0;
    SWE        = 1'b0;
    SADR       = '0;
    SDAT_W     = '0;
    SSEL       = '0;
    SCTI       = '0;
    SBTE       = '0;
    ack_vec    = '0;
    err_vec    = '0;
    case (state_reg)
      IDLE: begin
        if (|cyc_vec) begin
          state_next = OWN;
          gnt_next   = pick_gnt;
          owner_next = pick_idx;
        end
      end
      OWN: begin
        SCYC   = own_cyc && !timeout_hit;
        SSTB   = own_cyc && own_stb && !timeout_hit;
        SWE    = own_we;
        SADR   = own_adr;
        SDAT_W = own_dat;
        SSEL   = own_sel;
        SCTI   = own_cti;
        SBTE   = own_bte;
        ack_vec[owner_reg] = SACK;
        err_vec[owner_reg] = SERR || timeout_hit;
        if (!own_cyc) begin
          state_next = IDLE;
          gnt_next   = '0;
          last_next  = owner_reg;
        end else if (timeout_hit) begin
          state_next = ABORT;
        end else if (waiting) begin
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_next = IDLE;
          gnt_next   = '0;
          last_next  = owner_reg;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      last_reg  <= IW'(N_MASTERS - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign GNT = gnt_reg;

endmodule
